// File: rtl/forwarding_unit_pkg.sv
// Shared pipeline types and constants for the EX-stage forwarding logic.
// Imported by fwd_select and forwarding_unit.
package forwarding_unit_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int X0_IDX     = 0;

  typedef enum logic [1:0] {
    FWD_NONE   = 2'b00,
    FWD_MEM_WB = 2'b01,
    FWD_EX_MEM = 2'b10
  } fwd_sel_t;

  function automatic logic [1:0] fwd_hits(
    input fwd_sel_t a,
    input fwd_sel_t b,
    input fwd_sel_t kind
  );
    logic [1:0] n;
    n = 2'd0;
    if (a == kind) n = n + 2'd1;
    if (b == kind) n = n + 2'd1;
    return n;
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding select: picks the newest in-flight producer
// of one source register, never forwarding x0.
module fwd_select
  import forwarding_unit_pkg::*;
#(
  parameter int AW = REG_ADDR_W
) (
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] ex_mem_rd,
  input  logic          ex_mem_regwrite,
  input  logic [AW-1:0] mem_wb_rd,
  input  logic          mem_wb_regwrite,
  output fwd_sel_t      sel
);

  logic ex_hit;
  logic mem_hit;

  assign ex_hit = ex_mem_regwrite
               && (ex_mem_rd != AW'(X0_IDX))
               && (ex_mem_rd == src);

  assign mem_hit = mem_wb_regwrite
                && (mem_wb_rd != AW'(X0_IDX))
                && (mem_wb_rd == src);

  // EX/MEM holds the younger result, so it wins over MEM/WB.
  always_comb begin
    sel = FWD_NONE;
    if (ex_hit) begin
      sel = FWD_EX_MEM;
    end else if (mem_hit) begin
      sel = FWD_MEM_WB;
    end
  end

endmodule

// File: rtl/forwarding_unit.sv
// EX-stage forwarding selector with saturating forwarding-event counters.
// Selects are combinational and independent of clk/rst_n.
module forwarding_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_ex_rs1,
  input  logic [REG_ADDR_W-1:0] id_ex_rs2,
  input  logic [REG_ADDR_W-1:0] ex_mem_rd,
  input  logic [REG_ADDR_W-1:0] mem_wb_rd,
  input  logic                  ex_mem_regwrite,
  input  logic                  mem_wb_regwrite,
  input  logic                  cnt_en,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic [CNT_W-1:0]      fwd_ex_cnt,
  output logic [CNT_W-1:0]      fwd_mem_cnt
);

  import forwarding_unit_pkg::*;

  fwd_sel_t sel_a;
  fwd_sel_t sel_b;

  fwd_select #(
    .AW(REG_ADDR_W)
  ) u_sel_a (
    .src             (id_ex_rs1),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .sel             (sel_a)
  );

  fwd_select #(
    .AW(REG_ADDR_W)
  ) u_sel_b (
    .src             (id_ex_rs2),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .sel             (sel_b)
  );

  assign forward_a = sel_a;
  assign forward_b = sel_b;

  logic [1:0]   inc_ex;
  logic [1:0]   inc_mem;
  logic [CNT_W:0] sum_ex;
  logic [CNT_W:0] sum_mem;
  logic [CNT_W-1:0] nxt_ex;
  logic [CNT_W-1:0] nxt_mem;

  assign inc_ex  = fwd_hits(sel_a, sel_b, FWD_EX_MEM);
  assign inc_mem = fwd_hits(sel_a, sel_b, FWD_MEM_WB);

  // One guard bit catches overflow; clamp to all-ones instead of wrapping.
  always_comb begin
    sum_ex  = {1'b0, fwd_ex_cnt}
            + {{(CNT_W-1){1'b0}}, inc_ex};
    sum_mem = {1'b0, fwd_mem_cnt}
            + {{(CNT_W-1){1'b0}}, inc_mem};
    nxt_ex  = sum_ex[CNT_W-1:0];
    nxt_mem = sum_mem[CNT_W-1:0];
    if (sum_ex[CNT_W])  nxt_ex  = '1;
    if (sum_mem[CNT_W]) nxt_mem = '1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_ex_cnt  <= '0;
      fwd_mem_cnt <= '0;
    end else if (cnt_en) begin
      fwd_ex_cnt  <= nxt_ex;
      fwd_mem_cnt <= nxt_mem;
    end
  end

endmodule

// File: tb/tb_forwarding_unit.sv
// Directed bench for forwarding_unit, built with 4-bit counters
// so saturation is reachable quickly.
module tb_forwarding_unit;

  logic       clk;
  logic       rst_n;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] ex_rd;
  logic [4:0] wb_rd;
  logic       ex_we;
  logic       wb_we;
  logic       cnt_en;
  logic [1:0] fa;
  logic [1:0] fb;
  logic [3:0] ex_cnt;
  logic [3:0] mem_cnt;

  int tests;
  int fails;

  forwarding_unit #(
    .REG_ADDR_W(5),
    .CNT_W(4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_ex_rs1       (rs1),
    .id_ex_rs2       (rs2),
    .ex_mem_rd       (ex_rd),
    .mem_wb_rd       (wb_rd),
    .ex_mem_regwrite (ex_we),
    .mem_wb_regwrite (wb_we),
    .cnt_en          (cnt_en),
    .forward_a       (fa),
    .forward_b       (fb),
    .fwd_ex_cnt      (ex_cnt),
    .fwd_mem_cnt     (mem_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(
    input logic [4:0] a, input logic [4:0] b,
    input logic [4:0] er, input logic ew,
    input logic [4:0] wr, input logic ww
  );
    rs1 = a; rs2 = b;
    ex_rd = er; ex_we = ew;
    wb_rd = wr; wb_we = ww;
    #1;
  endtask

  task automatic chk_sel(
    input string nm, input logic [1:0] ea, input logic [1:0] eb
  );
    tests++;
    if (fa !== ea) begin
      fails++;
      $display("FAIL %s forward_a got %b want %b", nm, fa, ea);
    end
    tests++;
    if (fb !== eb) begin
      fails++;
      $display("FAIL %s forward_b got %b want %b", nm, fb, eb);
    end
  endtask

  task automatic chk_cnt(
    input string nm, input logic [3:0] ee, input logic [3:0] em
  );
    tests++;
    if (ex_cnt !== ee) begin
      fails++;
      $display("FAIL %s fwd_ex_cnt got %0d want %0d", nm, ex_cnt, ee);
    end
    tests++;
    if (mem_cnt !== em) begin
      fails++;
      $display("FAIL %s fwd_mem_cnt got %0d want %0d", nm, mem_cnt, em);
    end
  endtask

  task automatic clr_cnt();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    @(negedge clk);
    cnt_en = 1'b1;
    repeat (n) @(posedge clk);
    @(negedge clk);
    cnt_en = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cnt_en = 1'b1;
    drive(5'd1, 5'd2, 5'd1, 1'b1, 5'd2, 1'b1);
    repeat (2) @(negedge clk);
    chk_cnt("reset_hold", 4'd0, 4'd0);
    chk_sel("sel_in_reset", 2'b10, 2'b01);
    cnt_en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_no_fwd();
    drive(5'd1, 5'd2, 5'd3, 1'b0, 5'd4, 1'b0);
    chk_sel("no_fwd", 2'b00, 2'b00);
    run(2);
    chk_cnt("no_fwd_cnt", 4'd0, 4'd0);
    drive(5'd3, 5'd4, 5'd3, 1'b0, 5'd4, 1'b0);
    chk_sel("we_off_match", 2'b00, 2'b00);
  endtask

  task automatic test_ex_mem();
    drive(5'd1, 5'd2, 5'd1, 1'b1, 5'd9, 1'b0);
    chk_sel("ex_a", 2'b10, 2'b00);
    drive(5'd1, 5'd2, 5'd2, 1'b1, 5'd9, 1'b0);
    chk_sel("ex_b", 2'b00, 2'b10);
  endtask

  task automatic test_mem_wb();
    drive(5'd1, 5'd2, 5'd9, 1'b0, 5'd1, 1'b1);
    chk_sel("wb_a", 2'b01, 2'b00);
    drive(5'd1, 5'd2, 5'd9, 1'b0, 5'd2, 1'b1);
    chk_sel("wb_b", 2'b00, 2'b01);
  endtask

  task automatic test_x0_priority();
    drive(5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    chk_sel("x0_guard", 2'b00, 2'b00);
    drive(5'd0, 5'd7, 5'd0, 1'b1, 5'd7, 1'b1);
    chk_sel("x0_ex_only", 2'b00, 2'b01);
    drive(5'd5, 5'd6, 5'd5, 1'b1, 5'd5, 1'b1);
    chk_sel("prio_a", 2'b10, 2'b00);
    drive(5'd31, 5'd31, 5'd31, 1'b1, 5'd31, 1'b1);
    chk_sel("prio_both", 2'b10, 2'b10);
    drive(5'd9, 5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
    chk_sel("wb_both", 2'b01, 2'b01);
  endtask

  task automatic test_mixed();
    clr_cnt();
    drive(5'd1, 5'd2, 5'd1, 1'b1, 5'd2, 1'b1);
    chk_sel("mixed", 2'b10, 2'b01);
    run(3);
    chk_cnt("mixed_cnt", 4'd3, 4'd3);
    repeat (3) @(negedge clk);
    chk_cnt("hold_en0", 4'd3, 4'd3);
    drive(5'd4, 5'd4, 5'd9, 1'b0, 5'd4, 1'b1);
    run(2);
    chk_cnt("wb_inc2", 4'd3, 4'd7);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    cnt_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_cnt("async_clr", 4'd0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    chk_cnt("held_in_rst", 4'd0, 4'd0);
    drive(5'd1, 5'd2, 5'd1, 1'b1, 5'd2, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cnt_en = 1'b0;
    chk_cnt("resume", 4'd1, 4'd1);
  endtask

  task automatic test_saturation();
    clr_cnt();
    drive(5'd1, 5'd1, 5'd1, 1'b1, 5'd1, 1'b1);
    chk_sel("sat_sel", 2'b10, 2'b10);
    run(7);
    chk_cnt("sat_pre", 4'd14, 4'd0);
    run(1);
    chk_cnt("sat_edge", 4'd15, 4'd0);
    run(3);
    chk_cnt("sat_hold", 4'd15, 4'd0);
  endtask

  task automatic test_back_to_back();
    clr_cnt();
    @(negedge clk);
    cnt_en = 1'b1;
    drive(5'd3, 5'd8, 5'd3, 1'b1, 5'd8, 1'b1);
    @(negedge clk);
    drive(5'd3, 5'd8, 5'd8, 1'b1, 5'd3, 1'b1);
    chk_sel("b2b_swap", 2'b01, 2'b10);
    @(negedge clk);
    drive(5'd3, 5'd8, 5'd0, 1'b1, 5'd0, 1'b1);
    @(negedge clk);
    cnt_en = 1'b0;
    #1;
    chk_cnt("b2b_cnt", 4'd2, 4'd2);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rs1 = '0; rs2 = '0;
    ex_rd = '0; wb_rd = '0;
    ex_we = 1'b0; wb_we = 1'b0;
    cnt_en = 1'b0;
    rst_n = 1'b0;
    test_reset();
    test_no_fwd();
    test_ex_mem();
    test_mem_wb();
    test_x0_priority();
    test_mixed();
    test_async_reset();
    test_saturation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/forwarding_unit.md
Name: forwarding_unit

Overview:
- Data-hazard forwarding selector for the 5-stage RISC-V pipeline, sitting between the ID/EX register and the EX-stage ALU operand muxes.
- Compares ID/EX source registers against EX/MEM and MEM/WB destination registers and produces a 2-bit mux select per ALU operand.
- Select paths are purely combinational (same-cycle).
- A clocked section keeps saturating forwarding-event counters for performance monitoring.

Parameters:
- REG_ADDR_W, 5, register-index width (32 architectural registers).
- CNT_W, 32, width of each forwarding-event counter.

Ports:
- clk  input  1  pipeline clock; counters update on rising edge.
- rst_n  input  1  asynchronous active-low reset; clears counters only.
- id_ex_rs1  input  REG_ADDR_W  ID/EX source register 1 index.
- id_ex_rs2  input  REG_ADDR_W  ID/EX source register 2 index.
- ex_mem_rd  input  REG_ADDR_W  EX/MEM destination register index.
- mem_wb_rd  input  REG_ADDR_W  MEM/WB destination register index.
- ex_mem_regwrite  input  1  EX/MEM instruction writes rd.
- mem_wb_regwrite  input  1  MEM/WB instruction writes rd.
- cnt_en  input  1  counter update enable; counters hold when 0.
- forward_a  output  2  operand A select.
- forward_b  output  2  operand B select.
- fwd_ex_cnt  output  CNT_W  number of operands forwarded from EX/MEM.
- fwd_mem_cnt  output  CNT_W  number of operands forwarded from MEM/WB.

Behaviour:
- Select encoding:
  - 2'b00 = register file value (no forward).
  - 2'b10 = EX/MEM ALU result.
  - 2'b01 = MEM/WB writeback value.
  - 2'b11 is never driven.
- forward_a rule, zero-latency combinational, no dependency on clk or rst_n:
  - 10 if ex_mem_regwrite && ex_mem_rd != 0 && ex_mem_rd == id_ex_rs1;
  - else 01 if mem_wb_regwrite && mem_wb_rd != 0 && mem_wb_rd == id_ex_rs1;
  - else 00.
- forward_b: same rule using id_ex_rs2.
- Priority: when both stages match the same source, EX/MEM (newer result) wins and 10 is driven.
- Register x0 is never forwarded, even when regwrite is set and indices match.
- rs1 and rs2 are evaluated independently. Both may forward from the same or different stages in the same cycle.
- A regwrite of 0 suppresses any match from that stage regardless of rd.
- Counters, on each rising clk edge with cnt_en=1:
  - fwd_ex_cnt += (forward_a==10) + (forward_b==10).
  - fwd_mem_cnt += (forward_a==01) + (forward_b==01).
  - Each increment is 0, 1 or 2.
- Counters saturate at all-ones and never wrap. An increment that would exceed the maximum yields the maximum.
- Counters hold when cnt_en=0.
- Reset: rst_n low asynchronously forces fwd_ex_cnt and fwd_mem_cnt to 0. They stay 0 while rst_n is low.
- forward_a and forward_b are unaffected by reset and remain valid during reset.
- Deassertion of rst_n mid-operation: counting resumes on the first rising edge with rst_n high.
- X/unknown inputs are out of scope. Inputs are assumed driven by pipeline registers.

Decomposition:
- Shared pipeline package holds:
  - fwd_sel_t enum: FWD_NONE=2'b00, FWD_MEM_WB=2'b01, FWD_EX_MEM=2'b10;
  - REG_ADDR_W;
  - the x0 index constant.
- One natural sub-module: fwd_select. It takes one source index plus both stage (rd, regwrite) pairs and returns fwd_sel_t. It is instantiated twice, for rs1 and rs2.
- Counter logic stays in the top module.

Test Plan:
- No forwarding: rs1=1, rs2=2, ex_mem_rd=3, mem_wb_rd=4, both regwrite=0 -> forward_a=00, forward_b=00; counters unchanged.
- EX/MEM to each operand:
  - rs1=1, ex_mem_rd=1, ex_mem_regwrite=1, mem_wb_regwrite=0 -> a=10, b=00.
  - rs2=2, ex_mem_rd=2 -> a=00, b=10.
- MEM/WB to each operand:
  - mem_wb_rd=1, mem_wb_regwrite=1, ex_mem_regwrite=0 -> a=01, b=00.
  - mem_wb_rd=2 -> a=00, b=01.
- x0 guard and priority:
  - all indices 0, both regwrite=1 -> a=00, b=00.
  - rs1=5, ex_mem_rd=5, mem_wb_rd=5, both regwrite=1 -> a=10.
- Mixed: rs1=1, rs2=2, ex_mem_rd=1, mem_wb_rd=2, both regwrite=1 -> a=10, b=01. With cnt_en=1 for 3 cycles -> fwd_ex_cnt=3, fwd_mem_cnt=3.
- Reset and saturation:
  - rst_n low mid-count -> both counters 0 immediately, without waiting for a clock edge.
  - With CNT_W=4 and both operands forwarding from EX/MEM every cycle -> fwd_ex_cnt reaches 15 and holds.
